// File: rtl/mdec_pkg.sv
// mdec_pipe shared types
// class encodings and FSM states
package mdec_pkg;

  localparam logic [1:0] CLS_BR  = 2'b00;
  localparam logic [1:0] CLS_ALU = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_ILL = 2'b11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

endpackage

// File: rtl/mdec_fifo.sv
// mdec_pipe input queue
// sync FIFO with flush, extra ptr bit for full
module mdec_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // pointer update; flush drops all queued words
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mdec_pipe.sv
// buffered micro-instruction decoder
// FIFO -> classify -> registered result, branch bubbles
module mdec_pipe
  import mdec_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int DEPTH       = 4,
  parameter int BR_BUBBLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] ir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   br,
  output logic                   alu,
  output logic                   mem,
  output logic [ADDR_WIDTH-1:0]  br_addr,
  output logic                   ill_err,
  input  logic                   clr_err
);

  localparam int CW = (BR_BUBBLES > 0) ?
                      $clog2(BR_BUBBLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(BR_BUBBLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit HAS_BUB = (BR_BUBBLES > 0);

  logic [INSTR_WIDTH-1:0] head;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   load;
  logic                   hs;
  logic                   br_hold;
  logic                   permit;
  logic [1:0]             cls;
  logic                   unused_head;
  state_e                 state;
  logic [CW-1:0]          cnt;

  assign in_ready = !full && !rst && !flush;
  assign push     = in_valid && in_ready;
  assign cls      = head[INSTR_WIDTH-1 -: 2];
  assign hs       = out_valid && out_ready;
  assign br_hold  = HAS_BUB && hs && br;
  assign permit   = (state == ST_RUN) ? !br_hold
                                      : (cnt == CNT_ONE);
  assign pop      = !empty && (!out_valid || out_ready)
                    && permit && !flush;
  assign load     = pop && (cls != CLS_ILL);
  assign unused_head = ^head;

  mdec_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(INSTR_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (push),
    .din  (ir),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  // output register: load decode, else drain on handshake
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      br        <= 1'b0;
      alu       <= 1'b0;
      mem       <= 1'b0;
      br_addr   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      br        <= (cls == CLS_BR);
      alu       <= (cls == CLS_ALU);
      mem       <= (cls == CLS_MEM);
      br_addr   <= (cls == CLS_BR) ?
                   head[ADDR_WIDTH-1:0] : '0;
    end else if (hs) begin
      out_valid <= 1'b0;
      br        <= 1'b0;
      alu       <= 1'b0;
      mem       <= 1'b0;
      br_addr   <= '0;
    end
  end

  // bubble FSM: issued branch blocks loads for BR_BUBBLES edges
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (br_hold) begin
            state <= ST_BUBBLE;
            cnt   <= CNT_INIT;
          end
        end
        ST_BUBBLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_ONE) state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // sticky illegal flag, set beats clear
  always_ff @(posedge clk) begin
    if (rst)
      ill_err <= 1'b0;
    else if (pop && (cls == CLS_ILL))
      ill_err <= 1'b1;
    else if (clr_err)
      ill_err <= 1'b0;
  end

endmodule

// File: tb/tb_mdec_pipe.sv
// mdec_pipe bench
// cycle table on two configs plus issue-rate sequence
module tb_mdec_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, clr_err;
  logic [31:0] ir;

  logic       rdy0, ov0, br0, alu0, mem0, err0;
  logic       rdy1, ov1, br1, alu1, mem1, err1;
  logic [5:0] ad0, ad1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mdec_pipe #(
    .INSTR_WIDTH(32), .ADDR_WIDTH(6),
    .DEPTH(4), .BR_BUBBLES(2)
  ) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .ir(ir),
    .out_valid(ov0), .out_ready(out_ready),
    .br(br0), .alu(alu0), .mem(mem0), .br_addr(ad0),
    .ill_err(err0), .clr_err(clr_err)
  );

  mdec_pipe #(
    .INSTR_WIDTH(32), .ADDR_WIDTH(6),
    .DEPTH(4), .BR_BUBBLES(0)
  ) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .ir(ir),
    .out_valid(ov1), .out_ready(out_ready),
    .br(br1), .alu(alu1), .mem(mem1), .br_addr(ad1),
    .ill_err(err1), .clr_err(clr_err)
  );

  logic [11:0] got0, got1;
  assign got0 = {ov0, br0, alu0, mem0, ad0, err0, rdy0};
  assign got1 = {ov1, br1, alu1, mem1, ad1, err1, rdy1};

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ir;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic [11:0] exp0;
    logic [11:0] exp1;
  } vec_t;

  vec_t v[$];

  // {out_valid,br,alu,mem,br_addr,ill_err,in_ready}
  function automatic logic [11:0] ex(
    input logic o, b, a, m,
    input logic [5:0] ad,
    input logic e, r
  );
    return {o, b, a, m, ad, e, r};
  endfunction

  task automatic b2(
    input logic r, iv, input logic [31:0] w,
    input logic o, f, c,
    input logic [11:0] e0, e1
  );
    vec_t t;
    t.rst = r; t.iv = iv; t.ir = w;
    t.ordy = o; t.fl = f; t.clr = c;
    t.exp0 = e0; t.exp1 = e1;
    v.push_back(t);
  endtask

  task automatic a1(
    input logic r, iv, input logic [31:0] w,
    input logic o, f, c,
    input logic [11:0] e
  );
    b2(r, iv, w, o, f, c, e, e);
  endtask

  task automatic chk(
    input string nm,
    input logic [11:0] g, e
  );
    total_cnt++;
    if (g === e) pass_cnt++;
    else $display("FAIL %s got=%h expected=%h", nm, g, e);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0; ir = '0;

    // reset, latency
    a1(1,1,32'h4000_0000,1,0,0, ex(0,0,0,0,0,0,0));
    a1(1,1,32'h4000_0000,1,0,0, ex(0,0,0,0,0,0,0));
    a1(0,1,32'h4000_0000,1,0,0, ex(0,0,0,0,0,0,1));
    a1(0,0,32'h0,1,0,0, ex(0,0,0,0,0,0,1));
    a1(0,0,32'h0,1,0,0, ex(1,0,1,0,0,0,1));
    // branch bubbles (u1 has none)
    a1(0,1,32'h0000_002A,1,0,0, ex(0,0,0,0,0,0,1));
    a1(0,1,32'h4000_0001,1,0,0, ex(0,0,0,0,0,0,1));
    a1(0,0,32'h0,1,0,0, ex(1,1,0,0,6'h2A,0,1));
    b2(0,0,32'h0,1,0,0, ex(0,0,0,0,0,0,1),
                        ex(1,0,1,0,0,0,1));
    a1(0,0,32'h0,1,0,0, ex(0,0,0,0,0,0,1));
    b2(0,0,32'h0,1,0,0, ex(1,0,1,0,0,0,1),
                        ex(0,0,0,0,0,0,1));
    // illegal drop and sticky error
    a1(0,1,32'h4000_0000,1,0,0, ex(0,0,0,0,0,0,1));
    a1(0,1,32'hC000_0000,1,0,0, ex(0,0,0,0,0,0,1));
    a1(0,1,32'h4000_0002,1,0,0, ex(1,0,1,0,0,0,1));
    a1(0,0,32'h0,1,0,0, ex(0,0,0,0,0,1,1));
    a1(0,0,32'h0,1,0,0, ex(1,0,1,0,0,1,1));
    a1(0,1,32'hC000_0000,1,0,0, ex(0,0,0,0,0,1,1));
    a1(0,0,32'h0,1,0,1, ex(0,0,0,0,0,1,1));
    a1(0,0,32'h0,1,0,0, ex(0,0,0,0,0,1,1));
    a1(0,0,32'h0,1,0,1, ex(0,0,0,0,0,1,1));
    a1(0,0,32'h0,1,0,0, ex(0,0,0,0,0,0,1));
    // backpressure: 5 accepted, 6th refused
    a1(0,1,32'h8000_0000,0,0,0, ex(0,0,0,0,0,0,1));
    a1(0,1,32'h8000_0001,0,0,0, ex(0,0,0,0,0,0,1));
    a1(0,1,32'h8000_0002,0,0,0, ex(1,0,0,1,0,0,1));
    a1(0,1,32'h8000_0003,0,0,0, ex(1,0,0,1,0,0,1));
    a1(0,1,32'h8000_0004,0,0,0, ex(1,0,0,1,0,0,1));
    a1(0,1,32'h8000_0005,0,0,0, ex(1,0,0,1,0,0,0));
    a1(0,0,32'h0,1,0,0, ex(1,0,0,1,0,0,0));
    for (int k = 0; k < 4; k++)
      a1(0,0,32'h0,1,0,0, ex(1,0,0,1,0,0,1));
    // flush during bubble, 3 words queued
    a1(0,1,32'hC000_0000,1,0,0, ex(0,0,0,0,0,0,1));
    a1(0,1,32'h0000_0005,1,0,0, ex(0,0,0,0,0,0,1));
    a1(0,1,32'h4000_0000,1,0,0, ex(0,0,0,0,0,1,1));
    a1(0,1,32'h4000_0000,1,0,0, ex(1,1,0,0,6'h05,1,1));
    b2(0,1,32'h4000_0000,1,0,0, ex(0,0,0,0,0,1,1),
                                ex(1,0,1,0,0,1,1));
    b2(0,1,32'h0000_0011,1,1,0, ex(0,0,0,0,0,1,0),
                                ex(1,0,1,0,0,1,0));
    a1(0,0,32'h0,1,0,0, ex(0,0,0,0,0,1,1));
    a1(0,0,32'h0,1,0,0, ex(0,0,0,0,0,1,1));
    a1(0,1,32'h4000_0000,1,0,0, ex(0,0,0,0,0,1,1));
    a1(0,0,32'h0,1,0,0, ex(0,0,0,0,0,1,1));
    a1(0,0,32'h0,1,0,0, ex(1,0,1,0,0,1,1));
    a1(0,0,32'h0,1,0,0, ex(0,0,0,0,0,1,1));

    foreach (v[i]) begin
      @(negedge clk);
      rst       = v[i].rst;
      in_valid  = v[i].iv;
      ir        = v[i].ir;
      out_ready = v[i].ordy;
      flush     = v[i].fl;
      clr_err   = v[i].clr;
      #1;
      chk($sformatf("vec%0d.bub2", i), got0, v[i].exp0);
      chk($sformatf("vec%0d.bub0", i), got1, v[i].exp1);
    end

    // 8 back-to-back ALU words issue one per cycle
    for (int c = 0; c < 11; c++) begin
      logic o;
      @(negedge clk);
      in_valid  = (c < 8);
      ir        = 32'h4000_0000 | 32'(c);
      out_ready = 1'b1;
      flush     = 1'b0;
      clr_err   = 1'b0;
      #1;
      o = (c >= 2) && (c <= 9);
      chk($sformatf("stream%0d.bub2", c), got0,
          ex(o, 0, o, 0, 0, 1, 1));
      chk($sformatf("stream%0d.bub0", c), got1,
          ex(o, 0, o, 0, 0, 1, 1));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
